bram_stream_reader: RTL and testbench

//  Read-side controller for the simple dual-port block RAM in the BRAM shift-register IP.

---
 rtl/bram_stream_reader.sv | 209 ++++++++++++++++++++
 tb/tb_bram_stream_reader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
// Read-side controller for a registered-read dual-port RAM: turns (base, len) commands into a valid/ready stream.
// Optional abort port enabled by defining BRAM_READER_ABORT_EN.
module bram_stream_reader #(
    parameter int WIDTH = 16,
    parameter int SIZE  = 512,
    parameter int AW    = $clog2(SIZE),
    parameter int LW    = $clog2(SIZE + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_base,
    input  logic [LW-1:0]    cmd_len,
    output logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] read_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             done
`ifdef BRAM_READER_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam logic [LW-1:0] SIZE_LEN  = LW'(SIZE);
    localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [AW-1:0]    raddr_reg, raddr_next;
    logic [LW-1:0]    issue_left_reg, issue_left_next;
    logic             inflight_reg;
    logic             inflight_last_reg;
    logic             done_reg, done_next;
    logic             cmd_ready_reg, cmd_ready_next;

    logic [1:0]       count_reg;
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [WIDTH-1:0] fifo_data_reg [2];
    logic             fifo_last_reg [2];
    logic [1:0]       entry_we;

    logic             cmd_hs;
    logic [LW-1:0]    len_clamped;
    logic             pop;
    logic             push;
    logic             head_last;
    logic [2:0]       occ_after;
    logic             issue;
    logic             issue_last;
    logic             abort_hit;
    logic             burst_end;

`ifdef BRAM_READER_ABORT_EN
    assign abort_hit = abort && (state_reg != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    // The current raddr only counts as a read when buffer + in-flight word still fit after this cycle's pop.
    always_comb begin
        cmd_hs      = cmd_valid && cmd_ready_reg;
        len_clamped = (cmd_len > SIZE_LEN) ? SIZE_LEN : cmd_len;
        pop         = (count_reg != 2'd0) && m_ready;
        head_last   = fifo_last_reg[rd_ptr_reg];
        occ_after   = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
        issue       = (state_reg == ISSUE) && !abort_hit && (occ_after < 3'd2);
        issue_last  = issue && (issue_left_reg == LW'(1));
        push        = inflight_reg && !abort_hit;
        burst_end   = (state_reg == DRAIN) && pop && head_last && !abort_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (cmd_hs && (len_clamped != '0)) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (abort_hit) begin
                    state_next = IDLE;
                end else if (issue_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (abort_hit || burst_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        raddr_next      = raddr_reg;
        issue_left_next = issue_left_reg;
        done_next       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cmd_hs) begin
                    if (len_clamped != '0) begin
                        raddr_next      = cmd_base;
                        issue_left_next = len_clamped;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (abort_hit) begin
                    done_next = 1'b1;
                end else if (issue) begin
                    issue_left_next = issue_left_reg - LW'(1);
                    // Explicit wrap keeps addressing correct for non-power-of-two depths.
                    if (!issue_last) begin
                        raddr_next = (raddr_reg == LAST_ADDR) ? '0 : raddr_reg + AW'(1);
                    end
                end
            end
            DRAIN: begin
                done_next = abort_hit || burst_end;
            end
            default: done_next = 1'b0;
        endcase
        cmd_ready_next = (state_next == IDLE) && !done_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raddr_reg         <= '0;
            issue_left_reg    <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            done_reg          <= 1'b0;
            cmd_ready_reg     <= 1'b0;
        end else begin
            raddr_reg         <= raddr_next;
            issue_left_reg    <= issue_left_next;
            inflight_reg      <= issue;
            inflight_last_reg <= issue_last;
            done_reg          <= done_next;
            cmd_ready_reg     <= cmd_ready_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort_hit) begin
            count_reg  <= 2'd0;
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
        end else begin
            count_reg <= count_reg + {1'b0, push} - {1'b0, pop};
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry_we
            assign entry_we[gi] = push && (wr_ptr_reg == 1'(gi));
        end
    endgenerate

    // Each entry carries its last flag so m_last travels with the word through any stall.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                fifo_data_reg[i] <= '0;
                fifo_last_reg[i] <= 1'b0;
            end else if (entry_we[i]) begin
                fifo_data_reg[i] <= read_data;
                fifo_last_reg[i] <= inflight_last_reg;
            end
        end
    end

    assign cmd_ready = cmd_ready_reg;
    assign raddr     = raddr_reg;
    assign m_valid   = (count_reg != 2'd0);
    assign m_data    = fifo_data_reg[rd_ptr_reg];
    assign m_last    = m_valid && head_last;
    assign done      = done_reg;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: RAM model, directed plus randomized bursts against a queue reference.
module tb_bram_stream_reader;

    localparam int WIDTH = 16;
    localparam int SIZE  = 512;
    localparam int AW    = $clog2(SIZE);
    localparam int LW    = $clog2(SIZE + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_base;
    logic [LW-1:0]    cmd_len;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] read_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             done;
    logic             abort;

    logic [WIDTH-1:0] mem [SIZE];
    int checks = 0;
    int errors = 0;

    bram_stream_reader #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_base  (cmd_base),
        .cmd_len   (cmd_len),
        .raddr     (raddr),
        .read_data (read_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .done      (done)
`ifdef BRAM_READER_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    always #5 clk = ~clk;

    // Registered-read RAM: data for the address presented in a cycle appears the next cycle.
    always @(posedge clk) read_data <= mem[raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cmd_ready();
        int n;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_idle", cmd_ready, 1);
    endtask

    // Issues one command and consumes the stream, comparing against words read straight from mem.
    task automatic run_burst(input int base, input int len, input bit random_ready, input bit strict_timing);
        int eff;
        logic [WIDTH-1:0] exp_q[$];
        int idx;
        int cyc;
        int done_at;
        int budget;
        bit stalled;
        bit got_done;
        logic [WIDTH-1:0] held_data;
        logic held_last;

        eff = (len > SIZE) ? SIZE : len;
        for (int i = 0; i < eff; i++) exp_q.push_back(mem[(base + i) % SIZE]);

        wait_cmd_ready();
        cmd_valid = 1'b1;
        cmd_base  = AW'(base);
        cmd_len   = LW'(len);
        @(negedge clk);
        cmd_valid = 1'b0;

        idx       = 0;
        stalled   = 1'b0;
        got_done  = 1'b0;
        held_data = '0;
        held_last = 1'b0;
        done_at   = (eff == 0) ? 1 : -1;
        budget    = 4 * eff + 40;
        cyc       = 1;
        while (!got_done && cyc < budget) begin
            if (stalled) begin
                check("valid_held", m_valid, 1);
                check("data_held", m_data, held_data);
                check("last_held", m_last, held_last);
            end
            if (m_valid) begin
                if (idx < eff) begin
                    check("data", m_data, exp_q[idx]);
                    check("last", m_last, (idx == eff - 1));
                end else begin
                    check("extra_beat", m_valid, 0);
                end
            end
            if (strict_timing) check("valid_timing", m_valid, (cyc >= 3 && cyc < 3 + eff));
            check("done_timing", done, (cyc == done_at));
            check("cmd_ready_busy", cmd_ready, 0);
            if (done === 1'b1) got_done = 1'b1;

            m_ready   = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled   = m_valid && !m_ready;
            held_data = m_data;
            held_last = m_last;
            if (m_valid && m_ready) begin
                if (idx == eff - 1) done_at = cyc + 1;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        check("done_seen", got_done, 1);
        check("beat_count", idx, eff);
        check("cmd_ready_after_done", cmd_ready, 1);
        check("done_single_pulse", done, 0);
        $display("burst base=%0d len=%0d beats=%0d cycles=%0d", base, len, idx, cyc);
    endtask

    initial begin
        int base;
        int idx;
        int n;

        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        m_ready   = 1'b0;
        abort     = 1'b0;
        for (int i = 0; i < SIZE; i++) mem[i] = WIDTH'(i);

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_raddr", raddr, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("cmd_ready_after_rst", cmd_ready, 1);
        $display("reset released");

        run_burst(16, 4, 1'b0, 1'b1);
        run_burst(SIZE - 2, 4, 1'b0, 1'b1);
        run_burst(100, 0, 1'b0, 1'b1);

        for (int i = 0; i < SIZE; i++) mem[i] = WIDTH'($urandom);
        run_burst(int'($urandom_range(0, SIZE - 1)), 8, 1'b1, 1'b0);
        for (int t = 0; t < 8; t++) begin
            run_burst(int'($urandom_range(0, SIZE - 1)), int'($urandom_range(0, 24)), 1'b1, 1'b0);
        end
        run_burst(int'($urandom_range(0, SIZE - 1)), 1000, 1'b0, 1'b1);

        // Reset in the middle of a long burst.
        wait_cmd_ready();
        cmd_valid = 1'b1;
        cmd_base  = AW'(40);
        cmd_len   = LW'(16);
        m_ready   = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cmd_ready", cmd_ready, 0);
        check("midrst_raddr", raddr, 0);
        check("midrst_m_valid", m_valid, 0);
        check("midrst_m_data", m_data, 0);
        check("midrst_m_last", m_last, 0);
        check("midrst_done", done, 0);
        rst = 1'b0;
        @(negedge clk);
        check("postrst_done", done, 0);
        check("postrst_m_valid", m_valid, 0);
        check("postrst_cmd_ready", cmd_ready, 1);
        $display("mid-burst reset applied");
        run_burst(200, 2, 1'b0, 1'b1);

`ifdef BRAM_READER_ABORT_EN
        base = int'($urandom_range(0, SIZE - 1));
        wait_cmd_ready();
        cmd_valid = 1'b1;
        cmd_base  = AW'(base);
        cmd_len   = LW'(16);
        m_ready   = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        idx = 0;
        n = 0;
        while (!(m_valid === 1'b1 && idx == 4) && n < 40) begin
            if (m_valid === 1'b1) idx++;
            @(negedge clk);
            n++;
        end
        check("abort_fifth_valid", m_valid, 1);
        check("abort_fifth_data", m_data, mem[(base + 4) % SIZE]);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_m_valid", m_valid, 0);
        check("abort_done", done, 1);
        check("abort_cmd_ready_busy", cmd_ready, 0);
        @(negedge clk);
        check("abort_done_pulse", done, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_no_leak", m_valid, 0);
        @(negedge clk);
        check("abort_no_leak2", m_valid, 0);
        $display("abort burst base=%0d stopped at word 4", base);
        run_burst(int'($urandom_range(0, SIZE - 1)), 5, 1'b1, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
